lift_request_scheduler: RTL and testbench

//  Latches per-floor call requests and dispatches one target floor at a time to the lift datapath (current_floor/motor FSM).

---
 rtl/lift_pkg.sv | 17 +
 rtl/lift_scan_picker.sv | 74 +++++++
 rtl/lift_request_scheduler.sv | 167 ++++++++++++++++
 tb/tb_lift_request_scheduler.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lift_pkg.sv
// Shared definitions for the lift request scheduler: controller state
// encoding and sweep-direction constants.
package lift_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    MOVING   = 2'd2,
    DOOR     = 2'd3
  } lift_state_t;

  // Sweep direction encoding as carried on dir_up.
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/lift_scan_picker.sv
// SCAN target selection, purely combinational. Keeps the current sweep
// direction while any pending floor lies ahead of the lift and reverses
// otherwise. pick_valid is low when no pending floor exists other than
// the current one.
module lift_scan_picker
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS = 4,
  parameter int FLOOR_W    = 2
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  dir_up,
  output logic                  pick_valid,
  output logic [FLOOR_W-1:0]    pick_floor,
  output logic                  pick_dir_up
);

  logic               up_found_s;
  logic [FLOOR_W-1:0] up_floor_s;
  logic               dn_found_s;
  logic [FLOOR_W-1:0] dn_floor_s;

  // Nearest pending floor above (lowest) and below (highest) the lift.
  always_comb begin
    up_found_s = 1'b0;
    up_floor_s = {FLOOR_W{1'b0}};
    dn_found_s = 1'b0;
    dn_floor_s = {FLOOR_W{1'b0}};
    // Descending scan: the last hit is the lowest floor above.
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      up_found_s = (pending[i] && (FLOOR_W'(i) > current_floor)) ? 1'b1 : up_found_s;
      up_floor_s = (pending[i] && (FLOOR_W'(i) > current_floor)) ? FLOOR_W'(i) : up_floor_s;
    end
    // Ascending scan: the last hit is the highest floor below.
    for (int i = 0; i < NUM_FLOORS; i++) begin
      dn_found_s = (pending[i] && (FLOOR_W'(i) < current_floor)) ? 1'b1 : dn_found_s;
      dn_floor_s = (pending[i] && (FLOOR_W'(i) < current_floor)) ? FLOOR_W'(i) : dn_floor_s;
    end
  end

  // Continue the sweep if possible, otherwise reverse direction.
  always_comb begin
    pick_valid  = 1'b0;
    pick_floor  = current_floor;
    pick_dir_up = dir_up;
    if (dir_up == DIR_UP) begin
      if (up_found_s) begin
        pick_valid  = 1'b1;
        pick_floor  = up_floor_s;
        pick_dir_up = DIR_UP;
      end else if (dn_found_s) begin
        pick_valid  = 1'b1;
        pick_floor  = dn_floor_s;
        pick_dir_up = DIR_DN;
      end else begin
        pick_valid  = 1'b0;
      end
    end else begin
      if (dn_found_s) begin
        pick_valid  = 1'b1;
        pick_floor  = dn_floor_s;
        pick_dir_up = DIR_DN;
      end else if (up_found_s) begin
        pick_valid  = 1'b1;
        pick_floor  = up_floor_s;
        pick_dir_up = DIR_UP;
      end else begin
        pick_valid  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/lift_request_scheduler.sv
// Lift request scheduler: latches floor calls, dispatches one target at a
// time in SCAN order, waits for arrival and sequences the door dwell.
// Optional feature macro: LIFT_DOOR_HOLD_EN adds a door_hold input that
// keeps the door open while asserted; dwell counting restarts on release.
module lift_request_scheduler
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS  = 4,
  parameter int FLOOR_W     = 2,
  parameter int DOOR_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  lift_busy,
`ifdef LIFT_DOOR_HOLD_EN
  input  logic                  door_hold,
`endif
  output logic                  target_valid,
  output logic [FLOOR_W-1:0]    target_floor,
  input  logic                  target_ready,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up,
  output logic                  door_open
);

  localparam int              CNT_W      = $clog2(DOOR_CYCLES + 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DOOR_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};

  lift_state_t           state_r, state_n;
  logic [NUM_FLOORS-1:0] pending_r, pending_n;
  logic                  target_valid_r, target_valid_n;
  logic [FLOOR_W-1:0]    target_floor_r, target_floor_n;
  logic                  target_dir_r, target_dir_n;
  logic                  dir_up_r, dir_up_n;
  logic                  door_open_r, door_open_n;
  logic [CNT_W-1:0]      dwell_r, dwell_n;

  logic [NUM_FLOORS-1:0] cur_mask_s;
  logic                  cur_pend_s;
  logic                  dwell_restart_s;
  logic                  pick_valid_s;
  logic [FLOOR_W-1:0]    pick_floor_s;
  logic                  pick_dir_up_s;

  // One-hot of the lift's floor; out-of-range floors shift out to zero.
  assign cur_mask_s = NUM_FLOORS'(1'b1) << current_floor;
  assign cur_pend_s = |(pending_r & cur_mask_s);

`ifdef LIFT_DOOR_HOLD_EN
  assign dwell_restart_s = (|(call_req & cur_mask_s)) | door_hold;
`else
  assign dwell_restart_s = |(call_req & cur_mask_s);
`endif

  lift_scan_picker #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_picker (
    .pending       (pending_r),
    .current_floor (current_floor),
    .dir_up        (dir_up_r),
    .pick_valid    (pick_valid_s),
    .pick_floor    (pick_floor_s),
    .pick_dir_up   (pick_dir_up_s)
  );

  // Next state, pending bookkeeping and next values of the registered outputs.
  always_comb begin
    state_n        = state_r;
    pending_n      = pending_r | call_req;
    target_valid_n = target_valid_r;
    target_floor_n = target_floor_r;
    target_dir_n   = target_dir_r;
    dir_up_n       = dir_up_r;
    door_open_n    = door_open_r;
    dwell_n        = dwell_r;
    case (state_r)
      IDLE: begin
        if (cur_pend_s) begin
          // Call at the lift's own floor: open the door without travelling.
          state_n     = DOOR;
          pending_n   = (pending_r | call_req) & ~cur_mask_s;
          door_open_n = 1'b1;
          dwell_n     = DWELL_LOAD;
        end else if (pick_valid_s) begin
          // Target and its sweep direction are frozen until the transfer.
          state_n        = DISPATCH;
          target_valid_n = 1'b1;
          target_floor_n = pick_floor_s;
          target_dir_n   = pick_dir_up_s;
        end else begin
          state_n = IDLE;
        end
      end
      DISPATCH: begin
        if (target_ready) begin
          state_n        = MOVING;
          target_valid_n = 1'b0;
          dir_up_n       = target_dir_r;
        end else begin
          state_n = DISPATCH;
        end
      end
      MOVING: begin
        if (!lift_busy && (current_floor == target_floor_r)) begin
          state_n     = DOOR;
          pending_n   = (pending_r | call_req) & ~cur_mask_s;
          door_open_n = 1'b1;
          dwell_n     = DWELL_LOAD;
        end else begin
          state_n = MOVING;
        end
      end
      DOOR: begin
        // A call for the open floor only extends the dwell.
        pending_n = pending_r | (call_req & ~cur_mask_s);
        if (dwell_restart_s) begin
          dwell_n = DWELL_LOAD;
        end else if (dwell_r == CNT_ZERO) begin
          state_n     = IDLE;
          door_open_n = 1'b0;
        end else begin
          dwell_n = dwell_r - CNT_W'(1'b1);
        end
      end
      default: begin
        state_n        = IDLE;
        target_valid_n = 1'b0;
        door_open_n    = 1'b0;
        dwell_n        = CNT_ZERO;
      end
    endcase
  end

  // State and output registers; reset drops all latched calls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      pending_r      <= {NUM_FLOORS{1'b0}};
      target_valid_r <= 1'b0;
      target_floor_r <= {FLOOR_W{1'b0}};
      target_dir_r   <= DIR_UP;
      dir_up_r       <= DIR_UP;
      door_open_r    <= 1'b0;
      dwell_r        <= CNT_ZERO;
    end else begin
      state_r        <= state_n;
      pending_r      <= pending_n;
      target_valid_r <= target_valid_n;
      target_floor_r <= target_floor_n;
      target_dir_r   <= target_dir_n;
      dir_up_r       <= dir_up_n;
      door_open_r    <= door_open_n;
      dwell_r        <= dwell_n;
    end
  end

  assign target_valid = target_valid_r;
  assign target_floor = target_floor_r;
  assign pending      = pending_r;
  assign dir_up       = dir_up_r;
  assign door_open    = door_open_r;

endmodule

// File: tb/tb_lift_request_scheduler.sv
// Self-checking bench for lift_request_scheduler. Expected dispatches come
// from a sweep-level SCAN model and are queued; a monitor pops and compares
// them on every valid/ready transfer. A simple lift-core model answers
// dispatches with random accept and travel delays.
module tb_lift_request_scheduler;
  import lift_pkg::*;

  localparam int NF = 4;
  localparam int FW = 2;
  localparam int DC = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NF-1:0] call_req;
  logic [FW-1:0] current_floor;
  logic          lift_busy;
  logic          target_valid;
  logic [FW-1:0] target_floor;
  logic          target_ready;
  logic [NF-1:0] pending;
  logic          dir_up;
  logic          door_open;
`ifdef LIFT_DOOR_HOLD_EN
  logic          door_hold;
`endif

  lift_request_scheduler #(
    .NUM_FLOORS  (NF),
    .FLOOR_W     (FW),
    .DOOR_CYCLES (DC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .call_req      (call_req),
    .current_floor (current_floor),
    .lift_busy     (lift_busy),
`ifdef LIFT_DOOR_HOLD_EN
    .door_hold     (door_hold),
`endif
    .target_valid  (target_valid),
    .target_floor  (target_floor),
    .target_ready  (target_ready),
    .pending       (pending),
    .dir_up        (dir_up),
    .door_open     (door_open)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [FW-1:0] floor;
    logic          dir;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Lift-core model and reference-model state (driven by the main process).
  bit            core_en   = 1'b0;
  bit            mv_active = 1'b0;
  int            mv_cnt    = 0;
  logic [FW-1:0] mv_dest   = '0;
  int            m_floor   = 0;
  logic          m_dir     = 1'b1;

  // Monitor state.
  bit   mon_dchk = 1'b0;
  logic mon_dexp = 1'b1;
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // SCAN reference: serve the whole request set sweep by sweep.
  function automatic void model_run(input logic [NF-1:0] bits, output int doors);
    logic [NF-1:0] p;
    int            nxt;
    exp_t          e;
    p     = bits;
    doors = 0;
    if (p[m_floor]) begin
      p[m_floor] = 1'b0;
      doors++;
    end
    while (p != '0) begin
      nxt = -1;
      if (m_dir) begin
        for (int f = m_floor + 1; f < NF; f++) if (p[f] && nxt < 0) nxt = f;
        if (nxt < 0) begin
          m_dir = 1'b0;
          for (int f = m_floor - 1; f >= 0; f--) if (p[f] && nxt < 0) nxt = f;
        end
      end else begin
        for (int f = m_floor - 1; f >= 0; f--) if (p[f] && nxt < 0) nxt = f;
        if (nxt < 0) begin
          m_dir = 1'b1;
          for (int f = m_floor + 1; f < NF; f++) if (p[f] && nxt < 0) nxt = f;
        end
      end
      e.floor = FW'(nxt);
      e.dir   = m_dir;
      exp_q.push_back(e);
      m_floor = nxt;
      p[nxt]  = 1'b0;
      doors++;
    end
  endfunction

  task automatic core_step();
    if (mv_active) begin
      if (mv_cnt == 0) begin
        current_floor = mv_dest;
        lift_busy     = 1'b0;
        mv_active     = 1'b0;
      end else begin
        mv_cnt--;
      end
    end else if (target_ready) begin
      target_ready = 1'b0;
      if (!target_valid) begin
        mv_dest   = target_floor;
        mv_active = 1'b1;
        lift_busy = 1'b1;
        mv_cnt    = $urandom_range(1, 5);
      end
    end else if (target_valid) begin
      target_ready = ($urandom_range(0, 2) == 0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    call_req = '0;
    if (core_en) core_step();
  endtask

  task automatic count_door(output int n);
    n = 0;
    while (door_open === 1'b1 && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic run_out(input int exp_doors);
    int doors;
    int t;
    doors = 0;
    t     = 0;
    while (t < 600 && !(pending == '0 && door_open == 1'b0 && target_valid == 1'b0 &&
                        !mv_active && exp_q.size() == 0)) begin
      if (door_open) doors++;
      tick();
      t++;
    end
    if (t >= 600) begin
      n_checks++;
      n_fail++;
      $display("FAIL run_out_timeout: got %0d cycles, expected fewer than 600", t);
    end
    check("door_cycles", doors, exp_doors * DC);
    check("dir_up_end", dir_up, m_dir);
  endtask

  task automatic episode(input logic [NF-1:0] bits);
    int d;
    model_run(bits, d);
    call_req = bits;
    tick();
    run_out(d);
  endtask

  // Monitor: compare every transfer against the scoreboard queue.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_dchk = 1'b0;
      end else begin
        if (mon_dchk) begin
          check("dir_after_transfer", dir_up, mon_dexp);
          mon_dchk = 1'b0;
        end
        if (target_valid && target_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_dispatch: got floor %0d, expected no dispatch", target_floor);
          end else begin
            mon_e = exp_q.pop_front();
            check("dispatch_floor", target_floor, mon_e.floor);
            mon_dexp = mon_e.dir;
            mon_dchk = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    int   n;
    int   d;
    int   t;
    logic [NF-1:0] accum;
    logic [NF-1:0] b;
    rst_n         = 1'b0;
    call_req      = '0;
    current_floor = '0;
    lift_busy     = 1'b0;
    target_ready  = 1'b0;
`ifdef LIFT_DOOR_HOLD_EN
    door_hold     = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_target_valid", target_valid, 0);
    check("rst_target_floor", target_floor, 0);
    check("rst_pending", pending, 0);
    check("rst_dir_up", dir_up, 1);
    check("rst_door_open", door_open, 0);
    rst_n = 1'b1;
    tick();

    // 1: call to floor 1 from floor 0, offered two cycles later.
    call_req = 4'b0010;
    tick();
    check("t1_latched", pending, 4'b0010);
    check("t1_no_early_valid", target_valid, 0);
    tick();
    check("t1_valid", target_valid, 1);
    check("t1_floor", target_floor, 1);
    exp_q.push_back('{floor: 2'd1, dir: 1'b1});
    target_ready = 1'b1;
    tick();
    target_ready = 1'b0;
    check("t1_valid_drop", target_valid, 0);
    lift_busy = 1'b1;
    tick();
    tick();
    current_floor = 2'd1;
    lift_busy     = 1'b0;
    tick();
    count_door(n);
    check("t1_door_len", n, DC);
    check("t1_pending_clear", pending, 0);
    m_floor = 1;
    m_dir   = 1'b1;

    // 2: at 1 going up with calls 0 and 3: serve 3, reverse, serve 0.
    core_en = 1'b1;
    episode(4'b1001);

    // 3: call at the current floor: door only, dwell restart on re-call.
    call_req = NF'(1'b1) << current_floor;
    tick();
    tick();
    check("t3_door_open", door_open, 1);
    check("t3_no_valid", target_valid, 0);
    count_door(n);
    check("t3_door_len", n, DC);
    call_req = NF'(1'b1) << current_floor;
    tick();
    tick();
    repeat (3) tick();
    call_req = NF'(1'b1) << current_floor;
    tick();
    check("t3_recall_not_pending", pending, 0);
    count_door(n);
    check("t3_restart_len", n, DC);

    // 4: target held while ready stays low; new calls accumulate.
    core_en  = 1'b0;
    call_req = 4'b0100;
    tick();
    tick();
    check("t4_valid", target_valid, 1);
    check("t4_floor", target_floor, 2);
    accum = '0;
    for (int k = 0; k < 20; k++) begin
      b        = NF'($urandom) & 4'b1010;
      call_req = b;
      accum    = accum | b;
      tick();
      check("t4_floor_stable", target_floor, 2);
    end
    check("t4_valid_held", target_valid, 1);
    check("t4_pending_accum", pending, 4'b0100 | accum);
    exp_q.push_back('{floor: 2'd2, dir: 1'b1});
    m_floor = 2;
    m_dir   = 1'b1;
    model_run(accum, d);
    core_en = 1'b1;
    run_out(d + 1);

    // 5: asynchronous reset while moving with every floor pending.
    model_run(4'b1111, d);
    call_req = 4'b1111;
    tick();
    t = 0;
    while (!mv_active && t < 100) begin
      tick();
      t++;
    end
    check("t5_reached_moving", mv_active, 1);
    call_req = 4'b1111;
    tick();
    check("t5_pending_full", pending, 4'hF);
    #2 rst_n = 1'b0;
    #1;
    check("t5_target_valid", target_valid, 0);
    check("t5_target_floor", target_floor, 0);
    check("t5_pending", pending, 0);
    check("t5_dir_up", dir_up, 1);
    check("t5_door_open", door_open, 0);
    exp_q.delete();
    mv_active    = 1'b0;
    lift_busy    = 1'b0;
    target_ready = 1'b0;
    m_dir        = 1'b1;
    m_floor      = int'(current_floor);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("t5_pending_after", pending, 0);

    // Randomized call sets served to completion.
    for (int ep = 0; ep < 40; ep++) begin
      episode(NF'($urandom_range(1, (1 << NF) - 1)));
    end

`ifdef LIFT_DOOR_HOLD_EN
    // 6: door held open, then a full dwell after release.
    call_req = NF'(1'b1) << current_floor;
    tick();
    tick();
    check("t6_door_open", door_open, 1);
    door_hold = 1'b1;
    n = 0;
    repeat (30) begin
      tick();
      if (door_open) n++;
    end
    check("t6_held_open", n, 30);
    door_hold = 1'b0;
    count_door(n);
    check("t6_after_release", n, DC);
`endif

    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
